// File: rtl/lbist_pkg.sv
// lbist_pkg
//   Shared definitions for the LBIST pattern-application slice.
//   - lbist_state_e      : scan controller FSM state encoding
//   - LFSR_W             : width of the pattern LFSR state (65)
//   - DEFAULT_CHAIN_LEN  : default shift cycles per pattern load
//   - DEFAULT_N_PATTERNS : default patterns per session
package lbist_pkg;

   localparam int LFSR_W             = 65;
   localparam int DEFAULT_CHAIN_LEN  = 64;
   localparam int DEFAULT_N_PATTERNS = 1024;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SHIFT   = 3'd1,
      ST_CAPTURE = 3'd2,
      ST_FLUSH   = 3'd3,
      ST_DONE    = 3'd4
   } lbist_state_e;

endpackage

// File: rtl/lbist_phase_shifter.sv
// lbist_phase_shifter
//   Purely combinational XOR phase shifter. Each scan chain receives the
//   XOR of two LFSR taps PS_OFFSET apart (modulo the LFSR width), which
//   decorrelates neighbouring chains fed from adjacent LFSR stages.
// Ports:
//   lfsr_q  in  LFSR_W   : current LFSR state
//   scan_in out N_CHAINS : serial data for each scan chain
module lbist_phase_shifter
   import lbist_pkg::*;
#(
   parameter int N_CHAINS  = 8,
   parameter int PS_OFFSET = 17
) (
   input  logic [LFSR_W-1:0]   lfsr_q,
   output logic [N_CHAINS-1:0] scan_in
);

   for (genvar i = 0; i < N_CHAINS; i++) begin : g_chain
      localparam int TAP = (i + PS_OFFSET) % LFSR_W;
      assign scan_in[i] = lfsr_q[i] ^ lfsr_q[TAP];
   end

   // With few chains not every LFSR stage feeds a tap; fold the whole
   // vector into a sink so the unused stages are intentional.
   logic unused_lfsr_bits;
   assign unused_lfsr_bits = ^lfsr_q;

endmodule

// File: rtl/lbist_scan_ctrl.sv
// lbist_scan_ctrl
//   LBIST pattern-application controller. Sequences SHIFT / CAPTURE / FLUSH
//   for N_PATTERNS patterns, gates the LFSR advance and the MISR, and
//   reports busy/done to the test host.
// Handshake: start is a level request sampled only in IDLE and DONE; a
//   session runs to completion once started (start deassertion mid-run is
//   ignored), and DONE is held until start is seen low. abort is sampled
//   only while a session is active and returns the FSM to IDLE.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   start, abort : session request level, synchronous abort
//   lfsr_q       : LFSR state feeding the phase shifter
//   lfsr_en      : advance the LFSR this cycle
//   scan_en      : scan shift mode
//   scan_in      : per-chain serial inputs (combinational from lfsr_q)
//   capture      : one-cycle capture strobe
//   misr_en      : compact scan-out this cycle
//   busy, done   : session status
//   pattern_cnt  : patterns captured so far
//   dbg_state    : registered FSM state, for observation only
module lbist_scan_ctrl
   import lbist_pkg::*;
#(
   parameter int N_CHAINS   = 8,
   parameter int CHAIN_LEN  = DEFAULT_CHAIN_LEN,
   parameter int N_PATTERNS = DEFAULT_N_PATTERNS,
   parameter int PS_OFFSET  = 17
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              start,
   input  logic                              abort,
   input  logic [LFSR_W-1:0]                 lfsr_q,
   output logic                              lfsr_en,
   output logic                              scan_en,
   output logic [N_CHAINS-1:0]               scan_in,
   output logic                              capture,
   output logic                              misr_en,
   output logic                              busy,
   output logic                              done,
   output logic [$clog2(N_PATTERNS+1)-1:0]   pattern_cnt,
   output lbist_state_e                      dbg_state
);

   localparam int SW = $clog2(CHAIN_LEN);
   localparam int PW = $clog2(N_PATTERNS + 1);

   localparam logic [SW-1:0] SHIFT_LAST = SW'(CHAIN_LEN - 1);
   localparam logic [PW-1:0] PAT_LAST   = PW'(N_PATTERNS);

   lbist_state_e  state_q, state_d;
   logic [SW-1:0] shift_cnt_q, shift_cnt_d;
   logic [PW-1:0] pattern_cnt_q, pattern_cnt_d;
   logic [PW-1:0] pattern_inc;

   lbist_phase_shifter #(
      .N_CHAINS  (N_CHAINS),
      .PS_OFFSET (PS_OFFSET)
   ) u_phase_shifter (
      .lfsr_q  (lfsr_q),
      .scan_in (scan_in)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         shift_cnt_q   <= '0;
         pattern_cnt_q <= '0;
      end else begin
         state_q       <= state_d;
         shift_cnt_q   <= shift_cnt_d;
         pattern_cnt_q <= pattern_cnt_d;
      end
   end

   assign pattern_inc = pattern_cnt_q + PW'(1);

   // Next state, counters and control outputs. Outputs depend only on
   // registered state/counters so start and abort never reach them
   // combinationally.
   always_comb begin
      state_d       = state_q;
      shift_cnt_d   = shift_cnt_q;
      pattern_cnt_d = pattern_cnt_q;
      lfsr_en       = 1'b0;
      scan_en       = 1'b0;
      capture       = 1'b0;
      misr_en       = 1'b0;
      busy          = 1'b0;
      done          = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d     = ST_SHIFT;
               shift_cnt_d = '0;
            end
         end

         ST_SHIFT: begin
            scan_en = 1'b1;
            lfsr_en = 1'b1;
            busy    = 1'b1;
            // The first load has no previous response to unload.
            misr_en = (pattern_cnt_q != '0);
            if (abort) begin
               state_d       = ST_IDLE;
               shift_cnt_d   = '0;
               pattern_cnt_d = '0;
            end else if (shift_cnt_q == SHIFT_LAST) begin
               state_d     = ST_CAPTURE;
               shift_cnt_d = '0;
            end else begin
               shift_cnt_d = shift_cnt_q + SW'(1);
            end
         end

         ST_CAPTURE: begin
            capture = 1'b1;
            busy    = 1'b1;
            // abort beats the CAPTURE->FLUSH/SHIFT decision.
            if (abort) begin
               state_d       = ST_IDLE;
               shift_cnt_d   = '0;
               pattern_cnt_d = '0;
            end else begin
               pattern_cnt_d = pattern_inc;
               state_d       = (pattern_inc == PAT_LAST) ? ST_FLUSH : ST_SHIFT;
            end
         end

         ST_FLUSH: begin
            scan_en = 1'b1;
            misr_en = 1'b1;
            busy    = 1'b1;
            if (abort) begin
               state_d       = ST_IDLE;
               shift_cnt_d   = '0;
               pattern_cnt_d = '0;
            end else if (shift_cnt_q == SHIFT_LAST) begin
               state_d     = ST_DONE;
               shift_cnt_d = '0;
            end else begin
               shift_cnt_d = shift_cnt_q + SW'(1);
            end
         end

         ST_DONE: begin
            done = 1'b1;
            // No automatic re-run: start must be seen low before the
            // next session can be requested.
            if (!start) begin
               state_d       = ST_IDLE;
               pattern_cnt_d = '0;
            end
         end

         default: begin
            state_d       = ST_IDLE;
            shift_cnt_d   = '0;
            pattern_cnt_d = '0;
         end
      endcase
   end

   assign pattern_cnt = pattern_cnt_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_lbist_scan_ctrl.sv
// tb_lbist_scan_ctrl
//   Directed bench for lbist_scan_ctrl. Instance u_dut_a uses CHAIN_LEN=4,
//   N_PATTERNS=3, N_CHAINS=8, PS_OFFSET=17; instance u_dut_b uses
//   CHAIN_LEN=2, N_PATTERNS=1, N_CHAINS=4, PS_OFFSET=1.
module tb_lbist_scan_ctrl;
   import lbist_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // ---------------- DUT A ----------------
   logic               start_a, abort_a;
   logic [LFSR_W-1:0]  lfsr_q_a;
   logic               lfsr_en_a, scan_en_a, capture_a, misr_en_a, busy_a, done_a;
   logic [7:0]         scan_in_a;
   logic [1:0]         pattern_cnt_a;
   lbist_state_e       st_a;

   lbist_scan_ctrl #(
      .N_CHAINS(8), .CHAIN_LEN(4), .N_PATTERNS(3), .PS_OFFSET(17)
   ) u_dut_a (
      .clk(clk), .reset(reset), .start(start_a), .abort(abort_a),
      .lfsr_q(lfsr_q_a), .lfsr_en(lfsr_en_a), .scan_en(scan_en_a),
      .scan_in(scan_in_a), .capture(capture_a), .misr_en(misr_en_a),
      .busy(busy_a), .done(done_a), .pattern_cnt(pattern_cnt_a),
      .dbg_state(st_a)
   );

   // ---------------- DUT B ----------------
   logic               start_b, abort_b;
   logic [LFSR_W-1:0]  lfsr_q_b;
   logic               lfsr_en_b, scan_en_b, capture_b, misr_en_b, busy_b, done_b;
   logic [3:0]         scan_in_b;
   logic [0:0]         pattern_cnt_b;
   lbist_state_e       st_b;

   lbist_scan_ctrl #(
      .N_CHAINS(4), .CHAIN_LEN(2), .N_PATTERNS(1), .PS_OFFSET(1)
   ) u_dut_b (
      .clk(clk), .reset(reset), .start(start_b), .abort(abort_b),
      .lfsr_q(lfsr_q_b), .lfsr_en(lfsr_en_b), .scan_en(scan_en_b),
      .scan_in(scan_in_b), .capture(capture_b), .misr_en(misr_en_b),
      .busy(busy_b), .done(done_b), .pattern_cnt(pattern_cnt_b),
      .dbg_state(st_b)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_ctrl_a_zero(input string tag);
      check({tag, "_lfsr_en"}, 32'(lfsr_en_a), 32'd0);
      check({tag, "_scan_en"}, 32'(scan_en_a), 32'd0);
      check({tag, "_capture"}, 32'(capture_a), 32'd0);
      check({tag, "_misr_en"}, 32'(misr_en_a), 32'd0);
      check({tag, "_busy"},    32'(busy_a),    32'd0);
      check({tag, "_done"},    32'(done_a),    32'd0);
   endtask

   // ---------------- stimulus ----------------
   int   busy_cyc, n_lfsr, n_misr, n_cap, bad_adj, bad_ovl, n_misr_pre;
   int   cap_pos [3];
   logic prev_cap, seen_done, seen_scan;

   initial begin
      reset    = 1'b1;
      start_a  = 1'b0;
      abort_a  = 1'b0;
      lfsr_q_a = '0;
      start_b  = 1'b0;
      abort_b  = 1'b0;
      lfsr_q_b = '0;
      #2;

      // Reset state
      check_ctrl_a_zero("rst");
      check("rst_pattern_cnt", 32'(pattern_cnt_a), 32'd0);
      check("rst_state", 32'(st_a), 32'(ST_IDLE));

      // Phase shifter (scan_in follows lfsr_q even under reset)
      lfsr_q_a = 65'h1;                      #1; check("ps_bit0",   32'(scan_in_a), 32'h01);
      lfsr_q_a = 65'h1 << 17;                #1; check("ps_bit17",  32'(scan_in_a), 32'h01);
      lfsr_q_a = 65'h1 << 20;                #1; check("ps_bit20",  32'(scan_in_a), 32'h08);
      lfsr_q_a = 65'h1 << 5;                 #1; check("ps_bit5",   32'(scan_in_a), 32'h20);
      lfsr_q_a = (65'h1 << 17) | 65'h1;      #1; check("ps_cancel", 32'(scan_in_a), 32'h00);
      lfsr_q_a = 65'h1 << 64;                #1; check("ps_bit64",  32'(scan_in_a), 32'h00);
      lfsr_q_b = 65'h1;                      #1; check("psb_bit0",  32'(scan_in_b), 32'h1);
      lfsr_q_b = 65'h6;                      #1; check("psb_bits12",32'(scan_in_b), 32'h5);

      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("idle_busy", 32'(busy_a), 32'd0);
      check("idle_state", 32'(st_a), 32'(ST_IDLE));

      // Full run, start held high through DONE
      start_a = 1'b1;
      @(posedge clk);
      @(negedge clk);
      busy_cyc = 0; n_lfsr = 0; n_misr = 0; n_cap = 0; bad_adj = 0; bad_ovl = 0;
      prev_cap = 1'b0;
      for (int i = 0; i < 3; i++) cap_pos[i] = 0;
      for (int c = 0; c < 60; c++) begin
         if (done_a) break;
         if (busy_a) busy_cyc++;
         if (lfsr_en_a) n_lfsr++;
         if (misr_en_a) n_misr++;
         if (capture_a) begin
            if (n_cap < 3) cap_pos[n_cap] = busy_cyc;
            n_cap++;
            if (prev_cap) bad_adj++;
            if (scan_en_a) bad_ovl++;
         end
         prev_cap = capture_a;
         @(negedge clk);
      end
      check("run_done",        32'(done_a),        32'd1);
      check("run_busy_cycles", 32'(busy_cyc),      32'd19);
      check("run_cap_count",   32'(n_cap),         32'd3);
      check("run_cap0_pos",    32'(cap_pos[0]),    32'd5);
      check("run_cap1_pos",    32'(cap_pos[1]),    32'd10);
      check("run_cap2_pos",    32'(cap_pos[2]),    32'd15);
      check("run_lfsr_en",     32'(n_lfsr),        32'd12);
      check("run_misr_en",     32'(n_misr),        32'd12);
      check("run_cap_adjacent",32'(bad_adj),       32'd0);
      check("run_cap_scan_ovl",32'(bad_ovl),       32'd0);
      check("run_pattern_cnt", 32'(pattern_cnt_a), 32'd3);
      check("run_done_busy",   32'(busy_a),        32'd0);

      // Start held high: stay in DONE, no re-run
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("hold_done", 32'(done_a), 32'd1);
         check("hold_busy", 32'(busy_a), 32'd0);
      end
      check("hold_pattern_cnt", 32'(pattern_cnt_a), 32'd3);

      // abort in DONE is ignored
      abort_a = 1'b1;
      @(negedge clk);
      abort_a = 1'b0;
      check("done_abort_ign_state", 32'(st_a), 32'(ST_DONE));
      check("done_abort_ign_cnt",   32'(pattern_cnt_a), 32'd3);

      // Drop start one cycle, then raise: fresh run
      start_a = 1'b0;
      @(negedge clk);
      check("drop_state", 32'(st_a), 32'(ST_IDLE));
      check("drop_pattern_cnt", 32'(pattern_cnt_a), 32'd0);
      check("drop_done", 32'(done_a), 32'd0);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      check("fresh_busy",        32'(busy_a),        32'd1);
      check("fresh_lfsr_en",     32'(lfsr_en_a),     32'd1);
      check("fresh_misr_en",     32'(misr_en_a),     32'd0);
      check("fresh_pattern_cnt", 32'(pattern_cnt_a), 32'd0);

      // Run continues with start low; reset in SHIFT of pattern 2
      repeat (6) @(negedge clk);
      check("mid_state",       32'(st_a),          32'(ST_SHIFT));
      check("mid_pattern_cnt", 32'(pattern_cnt_a), 32'd1);
      check("mid_misr_en",     32'(misr_en_a),     32'd1);
      reset = 1'b1;
      #1;
      check_ctrl_a_zero("midrst");
      check("midrst_pattern_cnt", 32'(pattern_cnt_a), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("midrst_state", 32'(st_a), 32'(ST_IDLE));
      check("midrst_busy",  32'(busy_a), 32'd0);

      // Abort on the CAPTURE cycle of pattern 3
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      repeat (14) @(negedge clk);
      check("abort_at_capture",   32'(capture_a),     32'd1);
      check("abort_pre_cnt",      32'(pattern_cnt_a), 32'd2);
      abort_a = 1'b1;
      @(negedge clk);
      abort_a = 1'b0;
      check("abort_state",       32'(st_a),          32'(ST_IDLE));
      check("abort_pattern_cnt", 32'(pattern_cnt_a), 32'd0);
      check("abort_busy",        32'(busy_a),        32'd0);
      seen_done = 1'b0;
      seen_scan = 1'b0;
      for (int c = 0; c < 30; c++) begin
         seen_done |= done_a;
         seen_scan |= scan_en_a;
         @(negedge clk);
      end
      check("abort_no_done",  32'(seen_done), 32'd0);
      check("abort_no_flush", 32'(seen_scan), 32'd0);

      // Single pattern on DUT B
      start_b = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_b = 1'b0;
      busy_cyc = 0; n_lfsr = 0; n_misr = 0; n_misr_pre = 0; n_cap = 0;
      for (int c = 0; c < 30; c++) begin
         if (done_b) break;
         if (busy_b) busy_cyc++;
         if (lfsr_en_b) n_lfsr++;
         if (capture_b) n_cap++;
         if (misr_en_b) begin
            n_misr++;
            if (n_cap == 0) n_misr_pre++;
         end
         @(negedge clk);
      end
      check("b_done",        32'(done_b),        32'd1);
      check("b_busy_cycles", 32'(busy_cyc),      32'd5);
      check("b_cap_count",   32'(n_cap),         32'd1);
      check("b_lfsr_en",     32'(n_lfsr),        32'd2);
      check("b_misr_en",     32'(n_misr),        32'd2);
      check("b_misr_pre",    32'(n_misr_pre),    32'd0);
      check("b_pattern_cnt", 32'(pattern_cnt_b), 32'd1);

      // ---------------- report ----------------
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/lbist_scan_ctrl.md
# lbist_scan_ctrl

LBIST pattern-application controller, directly downstream of the 65-bit pattern LFSR. Consumes the LFSR state through an XOR phase shifter to drive N parallel scan chains. Sequences shift / capture / flush for a fixed pattern count, gates the LFSR advance (`lfsr_en`) and the response compactor (`misr_en`), and reports `busy`/`done` to the test host.

## Interface
Parameters:
- `N_CHAINS`, default 8: number of scan chains; legal range 1..65.
- `CHAIN_LEN`, default 64: shift cycles per load; minimum 2.
- `N_PATTERNS`, default 1024: patterns per run; minimum 1.
- `PS_OFFSET`, default 17: phase-shifter tap distance; legal range 1..64.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: level request to run a session.
- `abort` in 1: synchronous abort.
- `lfsr_q` in 65: LFSR state.
- `lfsr_en` out 1: advances the LFSR.
- `scan_en` out 1: scan shift mode.
- `scan_in` out N_CHAINS: chain serial inputs.
- `capture` out 1: one-cycle capture strobe.
- `misr_en` out 1: compacts scan-out this cycle.
- `busy` out 1: session in progress.
- `done` out 1: session complete.
- `pattern_cnt` out $clog2(N_PATTERNS+1): patterns captured so far.

## Operation
- FSM states: IDLE, SHIFT, CAPTURE, FLUSH, DONE.
- All control outputs are decoded from the registered state. There is no combinational path from `start` or `abort` to any control output.
- `scan_in` is combinational from `lfsr_q` only: `scan_in[i] = lfsr_q[i] ^ lfsr_q[(i+PS_OFFSET) mod 65]`.
- IDLE:
  - All control outputs are 0.
  - `start`=1 moves to SHIFT and clears `shift_cnt`.
- SHIFT:
  - `scan_en`=1, `lfsr_en`=1, `busy`=1.
  - `misr_en`=1 only when `pattern_cnt`>0, i.e. while unloading the previous response.
  - `shift_cnt` increments each cycle. At `shift_cnt`==CHAIN_LEN-1 the FSM moves to CAPTURE and `shift_cnt` clears.
- CAPTURE (exactly one cycle):
  - `capture`=1, `busy`=1, `scan_en`=0, `lfsr_en`=0, `misr_en`=0.
  - `pattern_cnt` increments on exit.
  - If the incremented value equals N_PATTERNS, go to FLUSH; otherwise go to SHIFT.
- FLUSH:
  - CHAIN_LEN cycles with `scan_en`=1, `misr_en`=1, `busy`=1, `lfsr_en`=0.
  - Then move to DONE.
- DONE:
  - `done`=1, `busy`=0.
  - `pattern_cnt` holds at N_PATTERNS.
  - Moves to IDLE when `start`=0. While `start` stays high, the FSM remains in DONE; no automatic re-run.
  - Leaving DONE for IDLE clears `pattern_cnt`.
- `abort`:
  - In SHIFT, CAPTURE or FLUSH, `abort`=1 forces IDLE next cycle and clears `shift_cnt` and `pattern_cnt`. No `done` is asserted.
  - `abort` has priority over every other transition, including CAPTURE→FLUSH.
  - `abort` in IDLE or DONE is ignored.
- `start` is sampled only in IDLE and DONE. Deassertion mid-run has no effect.
- Counters are sized to the ranges they must reach:
  - `shift_cnt` is $clog2(CHAIN_LEN) bits.
  - `pattern_cnt` is $clog2(N_PATTERNS+1) bits so it can reach N_PATTERNS.
  - Neither counter may wrap.

## Timing
- Reset (asynchronous):
  - State goes to IDLE; both counters go to 0.
  - `lfsr_en`, `scan_en`, `capture`, `misr_en`, `busy` and `done` are all 0.
  - `scan_in` follows `lfsr_q`.
- Reset mid-session returns the block immediately to IDLE. The LFSR is reset by the same signal, so the next run repeats the identical pattern sequence.
- Latency:
  - `start` sampled at edge k gives `busy`=`scan_en`=`lfsr_en`=1 from cycle k+1.
  - Total busy cycles = N_PATTERNS·(CHAIN_LEN+1)+CHAIN_LEN.
  - `done` rises the cycle after the last FLUSH cycle.
- Exactly CHAIN_LEN·N_PATTERNS `lfsr_en` cycles occur per run.
- Exactly CHAIN_LEN·N_PATTERNS `misr_en` cycles occur per run: (N_PATTERNS-1)·CHAIN_LEN during SHIFT plus CHAIN_LEN during FLUSH.
- `capture` is never adjacent to itself and never coincides with `scan_en`.

## Structure
- Shared `lbist_pkg` holds:
  - the state enum type;
  - `LFSR_W` = 65;
  - the default CHAIN_LEN and N_PATTERNS constants, also used by the MISR and the top level.
- Sub-module `lbist_phase_shifter`, purely combinational:
  - parameters N_CHAINS and PS_OFFSET;
  - input `lfsr_q`, output `scan_in`.
- The FSM and counters remain in `lbist_scan_ctrl`.

## Test plan
All scenarios use CHAIN_LEN=4, N_PATTERNS=3 unless noted.
- Reset and idle:
  - Stimulus: assert reset mid-SHIFT.
  - Response: all control outputs 0 and `pattern_cnt`=0 in the same cycle; FSM in IDLE after release.
- Full run:
  - Stimulus: one-cycle `start`.
  - Response: `busy` for exactly 19 cycles; `capture` pulses at busy cycles 5, 10 and 15; `lfsr_en` count=12; `misr_en` count=12; `done`=1 with `pattern_cnt`=3.
- Phase shifter:
  - Stimulus: `lfsr_q`=65'h1 with N_CHAINS=8.
  - Response: `scan_in`=8'h01.
  - Stimulus: `lfsr_q` with only bit 17 set.
  - Response: `scan_in`=8'h01, via the `lfsr_q[17]` tap for chain 0.
- Abort:
  - Stimulus: `abort` on the CAPTURE cycle of pattern 3.
  - Response: IDLE next cycle, no FLUSH, `done` never asserted, `pattern_cnt`=0.
- Start handling:
  - Stimulus: hold `start` high through DONE.
  - Response: `done` stays 1 and no new run starts.
  - Stimulus: drop `start` for one cycle, then raise it.
  - Response: a fresh run begins with `pattern_cnt`=0.
- Single pattern:
  - Stimulus: N_PATTERNS=1, CHAIN_LEN=2.
  - Response: 5 busy cycles; `misr_en` only in FLUSH.
